// File: rtl/sync_fifo_pkg.sv
// Shared size defaults for the single-clock byte FIFO.
package sync_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned BUF_WIDTH_DEF  = 3;
    localparam int unsigned DEPTH_DEF      = 2 ** BUF_WIDTH_DEF;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with one write port and a registered read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = BUF_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy counter and flags around sync_fifo_mem.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_WIDTH  = BUF_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic [BUF_WIDTH:0]    fifo_counter
);

    localparam int unsigned DEPTH = 2 ** BUF_WIDTH;
    localparam int unsigned CNT_W = BUF_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [BUF_WIDTH-1:0] wr_ptr;
    logic [BUF_WIDTH-1:0] rd_ptr;
    logic                 wr_ok;
    logic                 rd_ok;

    assign buf_empty = (fifo_counter == '0);
    assign buf_full  = (fifo_counter == FULL_CNT);
    assign wr_ok     = wr_en && !buf_full;
    assign rd_ok     = rd_en && !buf_empty;

    // Pointers wrap naturally at BUF_WIDTH bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + BUF_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + BUF_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_counter <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   fifo_counter <= fifo_counter + CNT_W'(1);
                2'b01:   fifo_counter <= fifo_counter - CNT_W'(1);
                default: fifo_counter <= fifo_counter;
            endcase
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (BUF_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (buf_in),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (buf_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo.
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] buf_in;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] buf_out;
    logic       buf_empty;
    logic       buf_full;
    logic [3:0] fifo_counter;

    int n_checks = 0;
    int n_errors = 0;

    sync_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .buf_in       (buf_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .fifo_counter (fifo_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        wr_en  = w;
        rd_en  = r;
        buf_in = d;
        tick();
        wr_en  = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cycle(1'b1, 1'b0, d);
    endtask

    task automatic pop();
        cycle(1'b0, 1'b1, 8'd0);
    endtask

    initial begin
        rst    = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        buf_in = 8'd0;

        // Reset held across clock edges
        tick();
        tick();
        check_eq("rst_count", 32'(fifo_counter), 32'd0);
        check_eq("rst_empty", 32'(buf_empty), 32'd1);
        check_eq("rst_full", 32'(buf_full), 32'd0);
        check_eq("rst_out", 32'(buf_out), 32'd0);
        rst = 1'b1;
        tick();
        check_eq("rel_count", 32'(fifo_counter), 32'd0);
        check_eq("rel_empty", 32'(buf_empty), 32'd1);
        check_eq("rel_out", 32'(buf_out), 32'd0);

        // Basic order
        push(8'd1);
        push(8'd2);
        pop();
        check_eq("basic_out1", 32'(buf_out), 32'd1);
        check_eq("basic_cnt1", 32'(fifo_counter), 32'd1);
        pop();
        check_eq("basic_out2", 32'(buf_out), 32'd2);
        check_eq("basic_empty", 32'(buf_empty), 32'd1);

        // Fill and overflow
        for (int i = 1; i <= 8; i++) push(8'(i * 10));
        check_eq("fill_cnt", 32'(fifo_counter), 32'd8);
        check_eq("fill_full", 32'(buf_full), 32'd1);
        push(8'd90);
        check_eq("ovf_cnt", 32'(fifo_counter), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            pop();
            check_eq("drain_out", 32'(buf_out), 32'(i * 10));
        end
        check_eq("drain_cnt", 32'(fifo_counter), 32'd0);

        // Underflow keeps last read value
        pop();
        check_eq("udf_out", 32'(buf_out), 32'd80);
        check_eq("udf_cnt", 32'(fifo_counter), 32'd0);
        check_eq("udf_empty", 32'(buf_empty), 32'd1);

        // Wrap-around, one in / one out
        for (int i = 1; i <= 20; i++) begin
            push(8'(i));
            check_eq("wrap_cnt1", 32'(fifo_counter), 32'd1);
            pop();
            check_eq("wrap_out", 32'(buf_out), 32'(i));
            check_eq("wrap_cnt0", 32'(fifo_counter), 32'd0);
        end

        // Simultaneous read/write with 3 entries
        push(8'd100);
        push(8'd101);
        push(8'd102);
        cycle(1'b1, 1'b1, 8'd103);
        check_eq("both_mid_out", 32'(buf_out), 32'd100);
        check_eq("both_mid_cnt", 32'(fifo_counter), 32'd3);
        for (int i = 1; i <= 3; i++) begin
            pop();
            check_eq("both_mid_drain", 32'(buf_out), 32'(100 + i));
        end

        // Simultaneous when full: read only
        for (int i = 0; i < 8; i++) push(8'(200 + i));
        cycle(1'b1, 1'b1, 8'd250);
        check_eq("both_full_cnt", 32'(fifo_counter), 32'd7);
        check_eq("both_full_out", 32'(buf_out), 32'd200);
        check_eq("both_full_flag", 32'(buf_full), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            pop();
            check_eq("both_full_drain", 32'(buf_out), 32'(200 + i));
        end
        check_eq("both_full_empty", 32'(buf_empty), 32'd1);

        // Simultaneous when empty: write only, no fall-through
        cycle(1'b1, 1'b1, 8'd55);
        check_eq("both_empty_cnt", 32'(fifo_counter), 32'd1);
        check_eq("both_empty_out", 32'(buf_out), 32'd207);
        pop();
        check_eq("both_empty_pop", 32'(buf_out), 32'd55);

        // Asynchronous reset with 5 entries held
        for (int i = 1; i <= 5; i++) push(8'(i + 30));
        check_eq("pre_rst_cnt", 32'(fifo_counter), 32'd5);
        #1;
        rst = 1'b0;
        #1;
        check_eq("arst_cnt", 32'(fifo_counter), 32'd0);
        check_eq("arst_empty", 32'(buf_empty), 32'd1);
        check_eq("arst_out", 32'(buf_out), 32'd0);
        #1;
        rst = 1'b1;
        push(8'd5);
        pop();
        check_eq("post_rst_out", 32'(buf_out), 32'd5);
        check_eq("post_rst_cnt", 32'(fifo_counter), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
